// File: rtl/register_file.sv
// MIPS 32x32 register file: two combinational read ports, one write port committed on the clk edge, and r0 hardwired to zero.
// Latency: reads 0 cycles, writes visible the next cycle; no backpressure. `REGFILE_WRITE_BYPASS_EN adds same-cycle write-to-read forwarding.
module register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [31:0]       WriteCount
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [31:0]       write_count;
  logic              wr_commit;
  logic [DATA_W-1:0] rd1_arr;
  logic [DATA_W-1:0] rd2_arr;

  // Writes that target r0 are dropped here, so they update neither the array nor the counter.
  assign wr_commit = RegWrite && (WriteReg != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      write_count <= '0;
    end else if (wr_commit) begin
      regs[WriteReg] <= WriteData;
      write_count    <= write_count + 32'd1;
    end
  end

  assign WriteCount = write_count;

  // r0 is forced to zero on the read side as well, so its value never depends on the array contents.
  assign rd1_arr = (ReadReg1 == '0) ? '0 : regs[ReadReg1];
  assign rd2_arr = (ReadReg2 == '0) ? '0 : regs[ReadReg2];

`ifdef REGFILE_WRITE_BYPASS_EN
  logic byp1;
  logic byp2;

  // Forwarding gives write-before-read ordering when write-back and decode happen in the same cycle.
  assign byp1 = wr_commit && !rst && (ReadReg1 == WriteReg);
  assign byp2 = wr_commit && !rst && (ReadReg2 == WriteReg);

  assign ReadData1 = byp1 ? WriteData : rd1_arr;
  assign ReadData2 = byp2 ? WriteData : rd2_arr;
`else
  assign ReadData1 = rd1_arr;
  assign ReadData2 = rd2_arr;
`endif

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file. It applies a table of write/read vectors, then runs hand sequences for reset, same-cycle access, back-to-back writes and counter wrap.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [31:0] WriteCount;

  int checks = 0;
  int fails  = 0;
  logic [31:0] sb [$];

  register_file #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .RegWrite(RegWrite), .WriteReg(WriteReg),
    .WriteData(WriteData), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .WriteCount(WriteCount)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && RegWrite)
      assert (!$isunknown(WriteReg))
      else $error("FAIL xz_writereg: WriteReg=%h while RegWrite=1", WriteReg);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic compare(input string nm, input logic [31:0] act);
    logic [31:0] exp;
    checks++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL %s: no expected value queued, got %h", nm, act);
    end else begin
      exp = sb.pop_front();
      if (act !== exp) begin
        fails++;
        $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
    end
  endtask

  task automatic expect_rd(input string nm, input logic [4:0] a1, input logic [4:0] a2,
                           input logic [31:0] e1, input logic [31:0] e2);
    ReadReg1 = a1;
    ReadReg2 = a2;
    sb.push_back(e1);
    sb.push_back(e2);
    #1;
    compare({nm, "_p1"}, ReadData1);
    compare({nm, "_p2"}, ReadData2);
  endtask

  task automatic expect_cnt(input string nm, input logic [31:0] e);
    sb.push_back(e);
    compare(nm, WriteCount);
  endtask

  // Entered and left on a falling edge; the write commits on the rising edge in between.
  task automatic do_write(input logic we, input logic [4:0] wa, input logic [31:0] wd);
    RegWrite  = we;
    WriteReg  = wa;
    WriteData = wd;
    @(posedge clk);
    @(negedge clk);
    RegWrite = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] ecnt;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [31:0] cnt0;
    logic [31:0] v;

    vecs[0] = '{1'b1, 5'd0,  32'h1234_5678, 5'd0,  5'd0,  32'h0,         32'h0,         32'd0};
    vecs[1] = '{1'b1, 5'd2,  32'hCAFE_F00D, 5'd2,  5'd0,  32'hCAFE_F00D, 32'h0,         32'd1};
    vecs[2] = '{1'b0, 5'd2,  32'hFFFF_FFFF, 5'd2,  5'd2,  32'hCAFE_F00D, 32'hCAFE_F00D, 32'd1};
    vecs[3] = '{1'b1, 5'd31, 32'h8000_0001, 5'd31, 5'd2,  32'h8000_0001, 32'hCAFE_F00D, 32'd2};
    vecs[4] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd31, 32'h0,         32'h8000_0001, 32'd2};
    vecs[5] = '{1'b0, 5'd0,  32'h1234_5678, 5'd0,  5'd0,  32'h0,         32'h0,         32'd2};

    rst = 1'b1;
    RegWrite = 1'b0;
    WriteReg = '0;
    WriteData = '0;
    ReadReg1 = '0;
    ReadReg2 = '0;

    // Writes attempted while reset is held must not take effect.
    @(negedge clk);
    RegWrite = 1'b1;
    WriteReg = 5'd5;
    WriteData = 32'hAAAA_5555;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    expect_rd("reset_hold", 5'd5, 5'd0, 32'h0, 32'h0);
    expect_cnt("reset_hold_cnt", 32'd0);
    RegWrite = 1'b0;

    @(negedge clk);
    rst = 1'b0;
    do_write(1'b1, 5'd5, 32'hDEAD_BEEF);
    expect_rd("first_write", 5'd5, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    expect_cnt("first_write_cnt", 32'd1);

    // Assert reset in the middle of the low phase, away from any clock edge.
    rst = 1'b1;
    expect_rd("async_rst", 5'd5, 5'd5, 32'h0, 32'h0);
    expect_cnt("async_rst_cnt", 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      do_write(vecs[i].we, vecs[i].wa, vecs[i].wd);
      expect_rd($sformatf("vec%0d", i), vecs[i].ra1, vecs[i].ra2, vecs[i].e1, vecs[i].e2);
      expect_cnt($sformatf("vec%0d_cnt", i), vecs[i].ecnt);
    end

    pulse_reset();
    for (int i = 1; i < 32; i++) begin
      do_write(1'b1, 5'(i), 32'(i) * 32'h0101_0101);
    end
    expect_cnt("sweep_cnt", 32'd31);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      expect_rd($sformatf("sweep%0d", i), 5'(i), 5'(31 - i),
                32'(i) * 32'h0101_0101, 32'(31 - i) * 32'h0101_0101);
    end

    do_write(1'b1, 5'd7, 32'h1111_1111);
    RegWrite = 1'b1;
    WriteReg = 5'd7;
    WriteData = 32'h2222_2222;
`ifdef REGFILE_WRITE_BYPASS_EN
    expect_rd("same_cycle_r7", 5'd7, 5'd7, 32'h2222_2222, 32'h2222_2222);
    expect_rd("same_cycle_split", 5'd7, 5'd8, 32'h2222_2222, 32'h0808_0808);
`else
    expect_rd("same_cycle_r7", 5'd7, 5'd7, 32'h1111_1111, 32'h1111_1111);
    expect_rd("same_cycle_split", 5'd7, 5'd8, 32'h1111_1111, 32'h0808_0808);
`endif
    @(posedge clk);
    @(negedge clk);
    RegWrite = 1'b0;
    expect_rd("next_cycle_r7", 5'd7, 5'd7, 32'h2222_2222, 32'h2222_2222);
    expect_cnt("r7_cnt", 32'd33);

    // Disabled write: data on the bus must neither be forwarded nor stored.
    RegWrite = 1'b0;
    WriteReg = 5'd7;
    WriteData = 32'h3333_3333;
    expect_rd("nowrite_same", 5'd7, 5'd7, 32'h2222_2222, 32'h2222_2222);
    @(posedge clk);
    @(negedge clk);
    expect_rd("nowrite_next", 5'd7, 5'd7, 32'h2222_2222, 32'h2222_2222);
    expect_cnt("nowrite_cnt", 32'd33);

    cnt0 = 32'd33;
    RegWrite = 1'b1;
    WriteReg = 5'd9;
    WriteData = 32'hA;
    @(posedge clk);
    @(negedge clk);
    WriteData = 32'hB;
    @(posedge clk);
    @(negedge clk);
    RegWrite = 1'b0;
    expect_rd("b2b_r9", 5'd9, 5'd9, 32'hB, 32'hB);
    expect_cnt("b2b_cnt", cnt0 + 32'd2);

    dut.write_count = 32'hFFFF_FFFF;
    #1;
    expect_cnt("deposit_cnt", 32'hFFFF_FFFF);
    @(negedge clk);
    do_write(1'b1, 5'd3, 32'h3C3C_3C3C);
    expect_cnt("wrap_cnt", 32'd0);
    v = 32'h3C3C_3C3C;
    expect_rd("wrap_r3", 5'd3, 5'd0, v, 32'h0);

    if (sb.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL scoreboard_drain: %0d expected values left, required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
